// File: rtl/defines.sv
// Shared encodings for the memory stage: access-size codes and write-back source codes.
// Latency: none (constants and a pure function).
// Backpressure: not applicable.
package defines;

   // WBHop access-size codes; 2'b11 is also treated as a word access.
   localparam logic [1:0] WB_WORD = 2'b00;
   localparam logic [1:0] WB_HALF = 2'b01;
   localparam logic [1:0] WB_BYTE = 2'b10;

   // wd_sel write-back source codes.
   localparam logic [1:0] WD_ALU  = 2'b00;
   localparam logic [1:0] WD_DM   = 2'b01;
   localparam logic [1:0] WD_PC8  = 2'b10;

   // Byte lanes touched by an access of the given size at the given byte offset.
   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] m;
      m = 4'b1111;
      if (size == WB_HALF) begin
         m = off[1] ? 4'b1100 : 4'b0011;
      end else if (size == WB_BYTE) begin
         m = 4'b0001 << off;
      end
      return m;
   endfunction

endpackage

// File: rtl/dm_ram.sv
// Data memory array: synchronous byte-masked write, combinational read, full clear on reset.
// Latency: write lands at posedge; read is combinational (0 cycles).
// Backpressure: none; accepts one write per cycle unconditionally.
// Ports: clk/reset; we + addr + wmask + wdata for writes; rdata = mem[addr].
module dm_ram #(
   parameter int WORDS = 4096,
   parameter int AW    = $clog2(WORDS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [3:0]    wmask,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem_q [WORDS];

   // Reset has priority, so a store presented in the reset cycle is discarded.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < WORDS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (wmask[b]) begin
               mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

   assign rdata = mem_q[addr];

endmodule

// File: rtl/dm_stage.sv
// MIPS memory stage: W->M store forwarding, byte/half/word store and extended load, MEM/WB register.
// Latency: 1 cycle EX/MEM -> MEM/WB; m_fwd_data_o is combinational.
// Backpressure: none; one instruction per cycle, bubbles arrive as all-zero inputs.
// Ports: EX/MEM fields (*_i), W-stage write-back (wb_*), M forwarding value, MEM/WB fields (*_o).
module dm_stage
   import defines::*;
#(
   parameter int DM_WORDS = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_i,
   input  logic [31:0] pcadd4_i,
   input  logic [31:0] AO_i,
   input  logic [31:0] RD2_i,
   input  logic [4:0]  a2_i,
   input  logic [4:0]  a3_i,
   input  logic        RegWE_i,
   input  logic        MemWE_i,
   input  logic [1:0]  Tnew_i,
   input  logic [1:0]  wd_sel_i,
   input  logic [1:0]  WBHop_i,
   input  logic        ld_unsigned_i,
   input  logic [31:0] wb_data_i,
   input  logic [4:0]  wb_a3_i,
   input  logic        wb_we_i,
   output logic [31:0] m_fwd_data_o,
   output logic [31:0] pc_o,
   output logic [31:0] pcadd4_o,
   output logic [31:0] AO_o,
   output logic [31:0] DR_o,
   output logic [4:0]  a3_o,
   output logic        RegWE_o,
   output logic [1:0]  Tnew_o,
   output logic [1:0]  wd_sel_o
);

   localparam int AW = $clog2(DM_WORDS);

   logic [31:0] sd;
   logic [3:0]  wmask;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [31:0] bitmask;
   logic [31:0] merged;
   logic [31:0] ld_data;

   logic [31:0] pc_d, pcadd4_d, AO_d, DR_d;
   logic [31:0] pc_q, pcadd4_q, AO_q, DR_q;
   logic [4:0]  a3_d, a3_q;
   logic        RegWE_d, RegWE_q;
   logic [1:0]  Tnew_d, Tnew_q;
   logic [1:0]  wd_sel_d, wd_sel_q;

   // Store data bypass from W: the instruction ahead may be writing our rt right now.
   assign sd = (wb_we_i && (wb_a3_i != 5'd0) && (wb_a3_i == a2_i)) ? wb_data_i : RD2_i;

   // Replicate the store value across all lanes; the mask picks the one(s) written.
   always_comb begin
      wmask = lane_mask(WBHop_i, AO_i[1:0]);
      wdata = sd;
      if (WBHop_i == WB_HALF) begin
         wdata = {2{sd[15:0]}};
      end else if (WBHop_i == WB_BYTE) begin
         wdata = {4{sd[7:0]}};
      end
      for (int b = 0; b < 4; b++) begin
         bitmask[8*b +: 8] = {8{wmask[b]}};
      end
      merged = (rdata & ~bitmask) | (wdata & bitmask);
   end

   dm_ram #(
      .WORDS (DM_WORDS),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .reset (reset),
      .we    (MemWE_i && !reset),
      .addr  (AO_i[AW+1:2]),
      .wmask (wmask),
      .wdata (wdata),
      .rdata (rdata)
   );

   // Load lane select and extension.
   always_comb begin
      logic [15:0] h;
      logic [7:0]  by;
      h  = AO_i[1] ? rdata[31:16] : rdata[15:0];
      by = rdata[8*AO_i[1:0] +: 8];
      ld_data = rdata;
      if (WBHop_i == WB_HALF) begin
         ld_data = ld_unsigned_i ? {16'h0, h} : {{16{h[15]}}, h};
      end else if (WBHop_i == WB_BYTE) begin
         ld_data = ld_unsigned_i ? {24'h0, by} : {{24{by[7]}}, by};
      end
   end

   // Memory data is never forwarded from M; only ALU result or link address.
   assign m_fwd_data_o = (wd_sel_i == WD_PC8) ? (pcadd4_i + 32'd4) : AO_i;

   always_comb begin
      pc_d     = pc_i;
      pcadd4_d = pcadd4_i;
      AO_d     = AO_i;
      DR_d     = ld_data;
      a3_d     = a3_i;
      RegWE_d  = RegWE_i;
      Tnew_d   = (Tnew_i == 2'd0) ? 2'd0 : Tnew_i - 2'd1;
      wd_sel_d = wd_sel_i;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q     <= '0;
         pcadd4_q <= '0;
         AO_q     <= '0;
         DR_q     <= '0;
         a3_q     <= '0;
         RegWE_q  <= 1'b0;
         Tnew_q   <= '0;
         wd_sel_q <= '0;
      end else begin
         pc_q     <= pc_d;
         pcadd4_q <= pcadd4_d;
         AO_q     <= AO_d;
         DR_q     <= DR_d;
         a3_q     <= a3_d;
         RegWE_q  <= RegWE_d;
         Tnew_q   <= Tnew_d;
         wd_sel_q <= wd_sel_d;
      end
   end

   assign pc_o     = pc_q;
   assign pcadd4_o = pcadd4_q;
   assign AO_o     = AO_q;
   assign DR_o     = DR_q;
   assign a3_o     = a3_q;
   assign RegWE_o  = RegWE_q;
   assign Tnew_o   = Tnew_q;
   assign wd_sel_o = wd_sel_q;

`ifndef SYNTHESIS
   // Store trace: PC, word-aligned byte address, word as it will be after the write.
   always_ff @(posedge clk) begin
      if (!reset && MemWE_i) begin
         $display("@%h: *%h <= %h", pc_i, {AO_i[31:2], 2'b00}, merged);
      end
   end
`endif

endmodule

// File: doc/dm_stage.md
# dm_stage

Memory-stage block of the five-stage pipelined MIPS core. It consumes the EX/MEM pipeline register outputs and performs the data-memory access: byte-enable store, extended load, W→M store-data forwarding. It then registers the result into the MEM/WB pipeline register. It also exports the M-stage forwarding source for the hazard unit.

## Interface
Parameters:
- `DM_WORDS`, default 4096: data memory depth in 32-bit words (16 KiB). Power of two.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `pc_i`, `pcadd4_i`  in  32  instruction PC and PC+4
- `AO_i`  in  32  ALU result / memory byte address
- `RD2_i`  in  32  store data (rt) as latched in EX/MEM
- `a2_i`, `a3_i`  in  5  rt index; destination register
- `RegWE_i`, `MemWE_i`  in  1  register write enable; memory write enable
- `Tnew_i`  in  2  cycles until result ready
- `wd_sel_i`  in  2  00 ALU, 01 memory, 10 PC+8
- `WBHop_i`  in  2  access size: 00 word, 01 half, 10 byte, 11 = word
- `ld_unsigned_i`  in  1  1 = zero-extend loads, 0 = sign-extend
- `wb_data_i`, `wb_a3_i`, `wb_we_i`  in  32/5/1  W-stage write-back value, target, enable
- `m_fwd_data_o`  out  32  M-stage forwarding value (combinational)
- `pc_o`, `pcadd4_o`, `AO_o`, `DR_o`  out  32  MEM/WB register; `DR_o` = extended load data
- `a3_o`  out  5; `RegWE_o`  out  1; `Tnew_o`  out  2; `wd_sel_o`  out  2  MEM/WB register

## Operation
- Store data: `sd = (wb_we_i && wb_a3_i!=0 && wb_a3_i==a2_i) ? wb_data_i : RD2_i`.
- Word index = `AO_i[log2(DM_WORDS)+1:2]`. Upper address bits are ignored.
- Store, when `MemWE_i` is 1 and `reset` is 0, with a read-modify-write merge into the addressed word:
  - Word: write all of `sd`.
  - Half: write `sd[15:0]` to bits `[31:16]` if `AO_i[1]` else `[15:0]`. `AO_i[0]` is ignored.
  - Byte: write `sd[7:0]` to byte lane `AO_i[1:0]`.
- Load: the array is read combinationally at the word index. The selected lane is chosen by the same rules, then extended per `ld_unsigned_i` (word: no extension).
- `m_fwd_data_o` = `pcadd4_i + 4` when `wd_sel_i` = 10, else `AO_i`. Memory data is never forwarded from M.
- Simulation-only write log on each store: `"@%h: *%h <= %h"` with `pc_i`, word-aligned address, merged word.

## Timing
- All state updates happen on `posedge clk`. The MEM/WB register has 1-cycle latency.
- `Tnew_o <= (Tnew_i==0) ? 0 : Tnew_i-1`. The decrement saturates and never wraps.
- `DR_o` captures the load result of the same cycle. A store followed by a load to the same word in the next cycle returns the merged value. The write lands at the edge before the load's read.
- Same-cycle store and load to one address cannot occur (single port, one instruction per stage).
- Reset (any cycle, including mid-stream) does the following:
  - All MEM/WB outputs go to 0.
  - Every memory word goes to 0.
  - The store presented in the reset cycle is discarded.
- No stall or flush port. Bubbles arrive as all-zero EX/MEM contents; `MemWE_i=0` means no write.

## Structure
- Shared package `defines` holds the `WBHop` size codes (`WB_WORD`, `WB_HALF`, `WB_BYTE`) and the `wd_sel` codes (`WD_ALU`, `WD_DM`, `WD_PC8`).
- One sub-module, `dm_ram`: the memory array with reset clear, byte-lane write mask, and combinational read.
- Lane select/extend logic and the pipeline register stay in `dm_stage`.

## Test plan
- Reset, then store word `0x12345678` at `AO=0x10`; next cycle load word at `0x10` → `DR_o=0x12345678`, write log `@pc: *00000010 <= 12345678`.
- Store byte `0xAB` at `0x13` over word `0x12345678` → word `0xAB345678`. Load byte signed at `0x13` → `0xFFFFFFAB`; unsigned → `0x000000AB`.
- Store half `0x8001` at `0x22`, then signed half load at `0x22` → `0xFFFF8001`. Half load at `0x23` gives the same result (`AO[0]` ignored).
- W→M forwarding:
  - `a2_i=5`, `RD2_i=0`, `wb_we_i=1`, `wb_a3_i=5`, `wb_data_i=0xCAFEF00D`, store word → memory holds `0xCAFEF00D`.
  - With `wb_a3_i=0` the store writes `RD2_i` instead.
- `Tnew_i` = 2 / 1 / 0 → `Tnew_o` = 1 / 0 / 0. With `wd_sel_i=10` and `pcadd4_i=0x3004`, `m_fwd_data_o=0x3008`.
- Assert `reset` in the same cycle as a store of `0xFFFFFFFF` to `0x40` → all MEM/WB outputs are 0 and a later load of `0x40` returns 0.
